// File: rtl/pulse_counter_tx_if.sv
// Bus bundle for pulse_counter_tx: ADC samples, tick periods, enables and the UART outputs.
`timescale 1ns/1ps
interface pulse_counter_tx_if #(
   parameter int unsigned NUM_INPUTS = 2,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned TIME_WIDTH = 32
);
   logic [NUM_INPUTS*DATA_WIDTH-1:0] in;
   logic [TIME_WIDTH-1:0]            sample_time;
   logic [TIME_WIDTH-1:0]            integration_time;
   logic                             sample_en;
   logic                             integration_en;
   logic                             transmit_en;
   logic                             sample_clk_pulse;
   logic                             integration_clk_pulse;
   logic                             tx;
   logic                             tx_busy;

   modport master (
      output in, sample_time, integration_time, sample_en, integration_en, transmit_en,
      input  sample_clk_pulse, integration_clk_pulse, tx, tx_busy
   );

   modport slave (
      input  in, sample_time, integration_time, sample_en, integration_en, transmit_en,
      output sample_clk_pulse, integration_clk_pulse, tx, tx_busy
   );
endinterface

// File: rtl/pulse_counter_tx.sv
// Accumulating pulse counter with programmable tick generators and an 8N1 word serializer.
// Optional pairwise product lanes are enabled by defining CROSS_PRODUCTS_EN.
`timescale 1ns/1ps
module pulse_counter_tx_tick #(
   parameter int unsigned TIME_WIDTH = 32,
   parameter int unsigned STEP_NS    = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_i,
   input  logic [TIME_WIDTH-1:0] period_i,
   output logic                  pulse_o
);
   localparam logic [TIME_WIDTH:0] STEP = (TIME_WIDTH+1)'(STEP_NS);

   logic [TIME_WIDTH-1:0] acc_q, acc_d;
   logic [TIME_WIDTH:0]   sum;
   logic                  hit;
   logic                  pulse_q;

   // One extra bit on the sum keeps the threshold compare free of wraparound.
   always_comb begin
      sum   = {1'b0, acc_q} + STEP;
      hit   = (sum >= {1'b0, period_i});
      acc_d = hit ? TIME_WIDTH'(sum - {1'b0, period_i}) : TIME_WIDTH'(sum);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         pulse_q <= 1'b0;
      end else if (!en_i) begin
         acc_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         pulse_q <= hit;
      end
   end

   assign pulse_o = pulse_q;
endmodule

module pulse_counter_tx #(
   parameter int unsigned CLK_FREQUENCY = 50000000,
   parameter int unsigned BAUD_RATE     = 230400,
   parameter int unsigned NUM_INPUTS    = 2,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned RESOLUTION    = 12,
   parameter int unsigned TIME_WIDTH    = 32
) (
   input logic               clk,
   input logic               rst_n,
   pulse_counter_tx_if.slave bus
);
   localparam int unsigned STEP_NS = 1000000000 / CLK_FREQUENCY;
   localparam int unsigned BAUD_NS = 1000000000 / BAUD_RATE;
`ifdef CROSS_PRODUCTS_EN
   localparam int unsigned NUM_C = NUM_INPUTS * (NUM_INPUTS - 1) / 2;
`else
   localparam int unsigned NUM_C = 0;
`endif
   localparam int unsigned NUM_L = NUM_C + NUM_INPUTS;
   localparam int unsigned W     = RESOLUTION * NUM_L;
   localparam int unsigned NB    = (W + 7) / 8;
   localparam int unsigned SHW   = NB * 8;
   localparam int unsigned BCW   = $clog2(NB + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   logic sample_pulse, integ_pulse, baud_pulse;

   pulse_counter_tx_tick #(.TIME_WIDTH(TIME_WIDTH), .STEP_NS(STEP_NS)) u_sample_tick (
      .clk(clk), .rst_n(rst_n), .en_i(bus.sample_en),
      .period_i(bus.sample_time), .pulse_o(sample_pulse)
   );

   pulse_counter_tx_tick #(.TIME_WIDTH(TIME_WIDTH), .STEP_NS(STEP_NS)) u_integ_tick (
      .clk(clk), .rst_n(rst_n), .en_i(bus.integration_en),
      .period_i(bus.integration_time), .pulse_o(integ_pulse)
   );

   pulse_counter_tx_tick #(.TIME_WIDTH(TIME_WIDTH), .STEP_NS(STEP_NS)) u_baud_tick (
      .clk(clk), .rst_n(rst_n), .en_i(1'b1),
      .period_i(TIME_WIDTH'(BAUD_NS)), .pulse_o(baud_pulse)
   );

   assign bus.sample_clk_pulse      = sample_pulse;
   assign bus.integration_clk_pulse = integ_pulse;

   logic [NUM_L*DATA_WIDTH-1:0] lane_in;
   logic [W-1:0]                cnt_q, cnt_d;
   logic [W-1:0]                snap_q, snap_d;

   function automatic logic [RESOLUTION-1:0] sat_add(input logic [RESOLUTION-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
      logic [RESOLUTION:0] s;
      s = {1'b0, a} + (RESOLUTION+1)'(b);
      return s[RESOLUTION] ? '1 : s[RESOLUTION-1:0];
   endfunction

   always_comb begin
      lane_in = '0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++)
         lane_in[(NUM_C+i)*DATA_WIDTH +: DATA_WIDTH] = bus.in[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef CROSS_PRODUCTS_EN
      // Products are taken at DATA_WIDTH, so only the low bits survive.
      for (int unsigned i = 0; i < NUM_INPUTS; i++)
         for (int unsigned j = i + 1; j < NUM_INPUTS; j++)
            lane_in[(i*(2*NUM_INPUTS-i-3)/2+j-1)*DATA_WIDTH +: DATA_WIDTH] =
               bus.in[i*DATA_WIDTH +: DATA_WIDTH] * bus.in[j*DATA_WIDTH +: DATA_WIDTH];
`endif
   end

   // An integration tick restarts each lane from zero, folding in a coincident sample.
   always_comb begin
      cnt_d  = cnt_q;
      snap_d = integ_pulse ? cnt_q : snap_q;
      for (int unsigned n = 0; n < NUM_L; n++)
         cnt_d[n*RESOLUTION +: RESOLUTION] =
            sat_add(integ_pulse ? '0 : cnt_q[n*RESOLUTION +: RESOLUTION],
                    sample_pulse ? lane_in[n*DATA_WIDTH +: DATA_WIDTH] : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         snap_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         snap_q <= snap_d;
      end
   end

   logic [2:0]     state_q, state_d;
   logic           tx_q, tx_d;
   logic [SHW-1:0] shift_q, shift_d;
   logic [2:0]     bit_q, bit_d;
   logic [BCW-1:0] byte_q, byte_d;

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      if (baud_pulse) begin
         case (state_q)
            S_IDLE: begin
               tx_d = 1'b1;
               if (bus.transmit_en) begin
                  shift_d = SHW'(snap_q);
                  byte_d  = '0;
                  tx_d    = 1'b0;
                  state_d = S_START;
               end
            end
            S_START: begin
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
               state_d = S_DATA;
            end
            S_DATA: begin
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 3'd1;
               end
            end
            S_STOP: begin
               tx_d = 1'b1;
               if (byte_q == BCW'(NB - 1)) begin
                  state_d = S_GAP;
               end else if (!bus.transmit_en) begin
                  state_d = S_IDLE;
               end else begin
                  byte_d  = byte_q + 1'b1;
                  tx_d    = 1'b0;
                  state_d = S_START;
               end
            end
            S_GAP: begin
               tx_d    = 1'b1;
               state_d = S_IDLE;
            end
            default: begin
               tx_d    = 1'b1;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tx_q    <= 1'b1;
         shift_q <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
      end
   end

   assign bus.tx      = tx_q;
   assign bus.tx_busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_pulse_counter_tx.sv
// Directed bench for pulse_counter_tx: tick timing, accumulation, saturation, UART frames, reset.
`timescale 1ns/1ps
module tb_pulse_counter_tx;
   localparam int BIT_NS = 4340;
   localparam int HALF_NS = 2170;
`ifdef CROSS_PRODUCTS_EN
   localparam int NB = 5;
   localparam logic [39:0] EXP_ACC = 40'h0_2D01_B087;
   localparam logic [39:0] EXP_SAT = 40'h0_00FF_F000;
`else
   localparam int NB = 3;
   localparam logic [39:0] EXP_ACC = 40'h00_0002_D01B;
   localparam logic [39:0] EXP_SAT = 40'h00_0000_0FFF;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_chk = 0;
   int n_pass = 0;

   always #10 clk = ~clk;

   pulse_counter_tx_if #(.NUM_INPUTS(2), .DATA_WIDTH(8), .TIME_WIDTH(32)) bus ();

   pulse_counter_tx #(
      .CLK_FREQUENCY(50000000), .BAUD_RATE(230400), .NUM_INPUTS(2),
      .DATA_WIDTH(8), .RESOLUTION(12), .TIME_WIDTH(32)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.sample_en = 1'b0;
      bus.integration_en = 1'b0;
      bus.transmit_en = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_integ(output int cyc);
      cyc = 0;
      for (int c = 1; c <= 300; c++) begin
         @(posedge clk); #1;
         if (bus.integration_clk_pulse) begin
            cyc = c;
            break;
         end
      end
   endtask

   task automatic wait_start(output logic seen);
      seen = 1'b0;
      for (int c = 0; c < 1000 && !seen; c++) begin
         @(posedge clk); #1;
         if (bus.tx === 1'b0) seen = 1'b1;
      end
   endtask

   task automatic rx_frame(input string tag, input logic [39:0] exp);
      logic seen;
      logic s, p;
      logic [7:0] d;
      wait_start(seen);
      check_val({tag, "_start_seen"}, 64'(seen), 64'd1);
      if (!seen) return;
      #HALF_NS;
      check_val({tag, "_busy"}, 64'(bus.tx_busy), 64'd1);
      for (int b = 0; b < NB; b++) begin
         s = bus.tx;
         for (int k = 0; k < 8; k++) begin
            #BIT_NS;
            d[k] = bus.tx;
         end
         #BIT_NS;
         p = bus.tx;
         check_val({tag, $sformatf("_byte%0d", b)}, 64'(d), 64'(exp[b*8 +: 8]));
         check_val({tag, $sformatf("_frm%0d", b)}, 64'({s, p}), 64'b01);
         #BIT_NS;
      end
      check_val({tag, "_gap"}, 64'({bus.tx, bus.tx_busy}), 64'b11);
      #BIT_NS;
      check_val({tag, "_idle"}, 64'({bus.tx, bus.tx_busy}), 64'b10);
   endtask

   initial begin
      logic [14:0] v15;
      logic [19:0] v20;
      logic [7:0]  d;
      logic        seen;
      int          cyc;

      bus.in = '0;
      bus.sample_time = 32'd100;
      bus.integration_time = 32'd1000;
      bus.sample_en = 1'b0;
      bus.integration_en = 1'b0;
      bus.transmit_en = 1'b0;

      repeat (2) @(posedge clk); #1;
      check_val("reset_out", 64'({bus.tx, bus.tx_busy, bus.sample_clk_pulse, bus.integration_clk_pulse}), 64'b1000);
      do_reset();

      // Tick generator: 100 ns period -> every 5th cycle
      bus.sample_en = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk); #1;
         v15[c-1] = bus.sample_clk_pulse;
      end
      check_val("tick100", 64'(v15), 64'h4210);
      @(negedge clk);
      bus.sample_en = 1'b0;
      @(negedge clk);
      bus.sample_time = 32'd0;
      bus.sample_en = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         v15[c] = bus.sample_clk_pulse;
      end
      check_val("tick0", 64'(v15[7:0]), 64'hFF);
      @(negedge clk);
      bus.sample_en = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         v20[c] = bus.sample_clk_pulse | bus.integration_clk_pulse;
      end
      check_val("tick_off", 64'(v20), 64'h0);

      // Accumulation window: in0=3, in1=5
      do_reset();
      bus.in = {8'd5, 8'd3};
      bus.sample_time = 32'd100;
      bus.integration_time = 32'd1000;
      bus.sample_en = 1'b1;
      bus.integration_en = 1'b1;
      wait_integ(cyc);
      check_val("integ_first", 64'(cyc), 64'd50);
      @(posedge clk); #1;
      bus.sample_en = 1'b0;
      bus.integration_en = 1'b0;
      bus.transmit_en = 1'b1;
      rx_frame("acc", EXP_ACC);
      bus.transmit_en = 1'b0;

      // transmit_en dropped during byte 0: byte finishes, rest dropped
      bus.transmit_en = 1'b1;
      wait_start(seen);
      check_val("drop_start_seen", 64'(seen), 64'd1);
      #HALF_NS;
      bus.transmit_en = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #BIT_NS;
         d[k] = bus.tx;
      end
      check_val("drop_byte0", 64'(d), 64'(EXP_ACC[7:0]));
      #BIT_NS;
      check_val("drop_stop", 64'({bus.tx, bus.tx_busy}), 64'b11);
      #BIT_NS;
      check_val("drop_idle1", 64'({bus.tx, bus.tx_busy}), 64'b10);
      #BIT_NS;
      check_val("drop_idle2", 64'({bus.tx, bus.tx_busy}), 64'b10);

      // Saturation: 19 samples of 255 before the first integration tick
      do_reset();
      bus.in = {8'd0, 8'd255};
      bus.sample_time = 32'd100;
      bus.integration_time = 32'd2000;
      bus.sample_en = 1'b1;
      bus.integration_en = 1'b1;
      wait_integ(cyc);
      check_val("sat_integ_first", 64'(cyc), 64'd100);
      @(posedge clk); #1;
      bus.sample_en = 1'b0;
      bus.integration_en = 1'b0;
      bus.transmit_en = 1'b1;
      rx_frame("sat", EXP_SAT);
      bus.transmit_en = 1'b0;

      // Asynchronous reset in the middle of a frame
      bus.sample_time = 32'd0;
      bus.integration_time = 32'd0;
      bus.sample_en = 1'b1;
      bus.integration_en = 1'b1;
      bus.transmit_en = 1'b1;
      wait_start(seen);
      check_val("rst_start_seen", 64'(seen), 64'd1);
      #(HALF_NS + 3 * BIT_NS);
      check_val("rst_pre", 64'({bus.tx_busy, bus.sample_clk_pulse, bus.integration_clk_pulse}), 64'b111);
      #7;
      rst_n = 1'b0;
      #1;
      check_val("rst_async", 64'({bus.tx, bus.tx_busy, bus.sample_clk_pulse, bus.integration_clk_pulse}), 64'b1000);
      bus.sample_en = 1'b0;
      bus.integration_en = 1'b0;
      bus.transmit_en = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus.transmit_en = 1'b1;
      rx_frame("post_rst", 40'h0);
      bus.transmit_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
